// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and 27 MHz default timing for the WS2812 frame
// controller.
//   state_t      controller FSM states (IDLE, LOAD, HIGH, LOW, LATCH)
//   enc_phase_t  bit-encoder phases
//   pixel_t      one 24-bit GRB pixel word, bit 23 sent first
//   DEF_*_CYC    default phase lengths in clk cycles at 27 MHz
//   max_int      helper used to size the shared phase timer
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    typedef enum logic [1:0] {ENC_IDLE, ENC_HIGH, ENC_LOW} enc_phase_t;

    typedef logic [23:0] pixel_t;

    localparam int DEF_T0H_CYC   = 11;    // ~0.40 us
    localparam int DEF_T0L_CYC   = 23;    // ~0.85 us
    localparam int DEF_T1H_CYC   = 23;
    localparam int DEF_T1L_CYC   = 11;
    localparam int DEF_RESET_CYC = 8100;  // 300 us latch

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// ws2812_frame_ctrl_if: host/strip bundle for ws2812_frame_ctrl.
//   wr_en/wr_addr/wr_data  pixel write strobe, index and GRB word
//   refresh_req            request one frame
//   busy/frame_done        frame status
//   ws_out                 strip data line
//   dbg_state/dbg_phase    controller state and encoder phase, for observation
//
// Strobe semantics: wr_en and refresh_req are single-cycle strobes sampled on
// every rising clk edge; there is no ready/back-pressure. A write is always
// accepted (unless its index is out of range). A refresh is accepted in IDLE,
// otherwise it sets a one-deep pending flag; refreshes arriving while the flag
// is already set are dropped. busy tells the host whether a frame is running
// or queued.
interface ws2812_frame_ctrl_if #(parameter int AW = 3);
    import ws2812_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    pixel_t        wr_data;
    logic          refresh_req;
    logic          busy;
    logic          frame_done;
    logic          ws_out;
    state_t        dbg_state;
    enc_phase_t    dbg_phase;

    modport master (
        output wr_en, wr_addr, wr_data, refresh_req,
        input  busy, frame_done, ws_out, dbg_state, dbg_phase
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh_req,
        output busy, frame_done, ws_out, dbg_state, dbg_phase
    );

endinterface

// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: drives one WS2812 bit as a HIGH phase then a LOW phase.
//   clk, rst   clock, synchronous active-high reset
//   start      begin a new bit on the next cycle (may coincide with bit_done)
//   bit_val    value of the bit being sent; held stable by the caller for the
//              whole bit
//   ws_out     registered line output (lags the phase by one cycle)
//   high_done  strobe in the last HIGH cycle
//   bit_done   strobe in the last LOW cycle
//   dbg_phase  current encoder phase
module ws2812_bit_enc
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T0L_CYC = DEF_T0L_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int T1L_CYC = DEF_T1L_CYC,
    parameter int TW      = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_val,
    output logic       ws_out,
    output logic       high_done,
    output logic       bit_done,
    output enc_phase_t dbg_phase
);

    localparam logic [TW-1:0] T0H_LAST = TW'(T0H_CYC - 1);
    localparam logic [TW-1:0] T0L_LAST = TW'(T0L_CYC - 1);
    localparam logic [TW-1:0] T1H_LAST = TW'(T1H_CYC - 1);
    localparam logic [TW-1:0] T1L_LAST = TW'(T1L_CYC - 1);

    enc_phase_t    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] hi_last, lo_last;
    logic          ws_q;

    always_comb begin
        hi_last   = bit_val ? T1H_LAST : T0H_LAST;
        lo_last   = bit_val ? T1L_LAST : T0L_LAST;
        phase_d   = phase_q;
        timer_d   = timer_q + TW'(1);
        high_done = 1'b0;
        bit_done  = 1'b0;
        case (phase_q)
            ENC_IDLE: timer_d = '0;
            ENC_HIGH: begin
                if (timer_q == hi_last) begin
                    high_done = 1'b1;
                    phase_d   = ENC_LOW;
                    timer_d   = '0;
                end
            end
            ENC_LOW: begin
                if (timer_q == lo_last) begin
                    bit_done = 1'b1;
                    phase_d  = ENC_IDLE;
                    timer_d  = '0;
                end
            end
            default: begin
                phase_d = ENC_IDLE;
                timer_d = '0;
            end
        endcase
        // A new bit may start in the same cycle the previous one finishes,
        // giving back-to-back bits with no gap.
        if (start) begin
            phase_d = ENC_HIGH;
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= ENC_IDLE;
            timer_q <= '0;
            ws_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            ws_q    <= (phase_q == ENC_HIGH);
        end
    end

    assign ws_out    = ws_q;
    assign dbg_phase = phase_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: pixel buffer plus frame sequencer for a WS2812 strip.
//   clk, rst  clock, synchronous active-high reset
//   bus       ws2812_frame_ctrl_if.slave (writes, refresh, status, ws_out)
// Buffer contents are not touched by rst; their power-up value comes from the
// device configuration (all zero).
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int LED_COUNT = 8,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T0L_CYC   = DEF_T0L_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int T1L_CYC   = DEF_T1L_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic clk,
    input  logic rst,
    ws2812_frame_ctrl_if.slave bus
);

    localparam int AW      = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam int MAX_CYC = max_int(max_int(max_int(T0H_CYC, T0L_CYC),
                                             max_int(T1H_CYC, T1L_CYC)), RESET_CYC);
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [AW-1:0] LAST_PIX   = AW'(LED_COUNT - 1);
    localparam logic [AW:0]   LED_CNT_W  = (AW + 1)'(LED_COUNT);
    localparam logic [TW-1:0] LATCH_LAST = TW'(RESET_CYC - 1);

    pixel_t        mem [LED_COUNT];
    state_t        state_q, state_d;
    logic [AW-1:0] pix_q;
    logic [4:0]    bit_q;
    pixel_t        shreg;
    logic          pending_q;
    logic [TW-1:0] lat_timer;
    logic          busy_q, done_q;
    logic          enc_start, high_done, bit_done, ws_enc;
    logic          latch_end, pend_eff;
    enc_phase_t    enc_phase;

    // Out-of-range writes are dropped. A LOAD in the same cycle reads the old
    // word because both sides are registered.
    always_ff @(posedge clk) begin
        if (bus.wr_en && ({1'b0, bus.wr_addr} < LED_CNT_W))
            mem[bus.wr_addr] <= bus.wr_data;
    end

    assign latch_end = (state_q == LATCH) && (lat_timer == LATCH_LAST);
    // A request landing in the final latch cycle is treated as pending so it
    // is not lost on the way back to IDLE.
    assign pend_eff  = pending_q | bus.refresh_req;

    always_comb begin
        state_d   = state_q;
        enc_start = 1'b0;
        case (state_q)
            IDLE:  if (bus.refresh_req) state_d = LOAD;
            LOAD: begin
                state_d   = HIGH;
                enc_start = 1'b1;
            end
            HIGH:  if (high_done) state_d = LOW;
            LOW: begin
                if (bit_done) begin
                    if (bit_q != 5'd0) begin
                        state_d   = HIGH;
                        enc_start = 1'b1;
                    end else if (pix_q == LAST_PIX) begin
                        state_d = LATCH;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LATCH: if (latch_end) state_d = pend_eff ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            bit_q     <= '0;
            shreg     <= '0;
            pending_q <= 1'b0;
            lat_timer <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= latch_end;
            // busy drops in step with frame_done unless a pending refresh
            // restarts straight into LOAD.
            busy_q  <= (state_q != IDLE) && !(latch_end && !pend_eff);
            if (latch_end)
                pending_q <= 1'b0;
            else if (state_q != IDLE && bus.refresh_req)
                pending_q <= 1'b1;
            lat_timer <= (state_q == LATCH && !latch_end) ? lat_timer + TW'(1) : '0;
            case (state_q)
                IDLE: pix_q <= '0;
                LOAD: begin
                    shreg <= mem[pix_q];
                    bit_q <= 5'd23;
                end
                LOW: begin
                    if (bit_done) begin
                        if (bit_q != 5'd0) begin
                            shreg <= {shreg[22:0], 1'b0};
                            bit_q <= bit_q - 5'd1;
                        end else if (pix_q != LAST_PIX) begin
                            pix_q <= pix_q + AW'(1);
                        end
                    end
                end
                LATCH: if (latch_end) pix_q <= '0;
                default: ;
            endcase
        end
    end

    ws2812_bit_enc #(
        .T0H_CYC (T0H_CYC),
        .T0L_CYC (T0L_CYC),
        .T1H_CYC (T1H_CYC),
        .T1L_CYC (T1L_CYC),
        .TW      (TW)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .start     (enc_start),
        .bit_val   (shreg[23]),
        .ws_out    (ws_enc),
        .high_done (high_done),
        .bit_done  (bit_done),
        .dbg_phase (enc_phase)
    );

    assign bus.ws_out     = ws_enc;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_phase  = enc_phase;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: directed stimulus with a pixel scoreboard. The
// stimulus pushes the pixel words each frame must carry into exp_q; a monitor
// decodes ws_out into bits and pixels and checks phase lengths and words.
module tb_ws2812_frame_ctrl;
    import ws2812_pkg::*;

    localparam int LED   = 3;
    localparam int AW    = 2;
    localparam int T0H   = 11;
    localparam int T0L   = 23;
    localparam int T1H   = 23;
    localparam int T1L   = 11;
    localparam int RSTC  = 8100;
    localparam int FRAME_BUDGET = 12000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ws2812_frame_ctrl_if #(.AW(AW)) bus ();

    ws2812_frame_ctrl #(
        .LED_COUNT (LED),
        .T0H_CYC   (T0H),
        .T0L_CYC   (T0L),
        .T1H_CYC   (T1H),
        .T1L_CYC   (T1L),
        .RESET_CYC (RSTC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pix(input logic [AW-1:0] addr, input logic [23:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_refresh();
        bus.refresh_req = 1'b1;
        tick();
        bus.refresh_req = 1'b0;
    endtask

    task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
        exp_q.push_back(p0);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
    endtask

    // Refresh from IDLE with the start-latency checks.
    task automatic refresh_from_idle_checked();
        pulse_refresh();
        tick();
        check("busy_at_t1", bus.busy, 1);
        check("ws_low_at_t1", bus.ws_out, 0);
        tick();
        check("ws_high_at_t2", bus.ws_out, 1);
    endtask

    // Runs until n frame_done pulses or the budget runs out.
    task automatic run_until_done(input int n, input int budget,
                                  output logic first_busy, output logic last_busy,
                                  output logic busy_gap);
        int seen = 0;
        first_busy = 1'b0;
        last_busy  = 1'b0;
        busy_gap   = 1'b0;
        for (int c = 0; c < budget && seen < n; c++) begin
            tick();
            if (bus.frame_done) begin
                if (seen == 0) first_busy = bus.busy;
                last_busy = bus.busy;
                seen++;
            end else if (!bus.busy) begin
                busy_gap = 1'b1;
            end
        end
        check("frame_done_count", seen, n);
    endtask

    // ---------------- monitor ----------------
    int          mon_frames = 0;
    logic        resync = 1'b1;
    logic        prev_ws = 1'b0;
    logic        frame_active = 1'b0;
    logic        last_bit = 1'b0;
    logic        pix_gap = 1'b0;
    logic        any_bit = 1'b0;
    int          hi_cnt = 0;
    int          lo_cnt = 0;
    int          bit_idx = 0;
    int          pix_cnt = 0;
    logic [23:0] got_word = '0;

    always @(negedge clk) begin
        logic [23:0] w;
        logic        b;
        if (rst) begin
            resync = 1'b1;
        end else if (resync) begin
            if (!bus.ws_out) begin
                resync       = 1'b0;
                prev_ws      = 1'b0;
                frame_active = 1'b0;
                any_bit      = 1'b0;
                pix_gap      = 1'b0;
                lo_cnt       = 0;
                bit_idx      = 0;
                pix_cnt      = 0;
            end
        end else begin
            if (bus.ws_out && !prev_ws) begin
                if (frame_active && any_bit)
                    check("low_len", lo_cnt, (last_bit ? T1L : T0L) + (pix_gap ? 1 : 0));
                if (!frame_active) begin
                    frame_active = 1'b1;
                    any_bit      = 1'b0;
                    bit_idx      = 0;
                    pix_cnt      = 0;
                end
                pix_gap = 1'b0;
                hi_cnt  = 1;
            end else if (bus.ws_out) begin
                hi_cnt++;
            end else if (prev_ws) begin
                b = (hi_cnt > 17);
                if (exp_q.size() > 0) begin
                    w = exp_q[0];
                    check("high_len", hi_cnt, w[5'(23 - bit_idx)] ? T1H : T0H);
                end else begin
                    check("exp_q_nonempty", exp_q.size(), 1);
                end
                got_word = {got_word[22:0], b};
                last_bit = b;
                any_bit  = 1'b1;
                lo_cnt   = 1;
                bit_idx++;
                if (bit_idx == 24) begin
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("pixel_word", got_word, w);
                    end
                    bit_idx = 0;
                    pix_cnt++;
                    pix_gap = (pix_cnt < LED);
                end
            end else begin
                lo_cnt++;
            end
            if (bus.frame_done) begin
                check("frame_done_in_frame", frame_active, 1);
                if (frame_active) begin
                    check("pixels_per_frame", pix_cnt, LED);
                    check("bit_idx_at_done", bit_idx, 0);
                    check("latch_low_len", lo_cnt, (last_bit ? T1L : T0L) + RSTC);
                    mon_frames++;
                end
                frame_active = 1'b0;
            end
            prev_ws = bus.ws_out;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic fb, lb, gap;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.refresh_req = 1'b0;

        repeat (5) tick();
        check("rst_ws_out", bus.ws_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_state", bus.dbg_state, IDLE);
        rst = 1'b0;
        tick();

        // F1: basic frame
        write_pix(2'd0, 24'hFF0000);
        write_pix(2'd1, 24'h000001);
        write_pix(2'd2, 24'h800001);
        push_frame(24'hFF0000, 24'h000001, 24'h800001);
        refresh_from_idle_checked();
        run_until_done(1, FRAME_BUDGET, fb, lb, gap);
        check("f1_busy_at_done", lb, 0);
        tick();
        check("f1_idle_after", bus.dbg_state, IDLE);

        // F2/F3: three requests -> two frames; writes during pixel 0 of F2
        push_frame(24'hFF0000, 24'h00FF00, 24'h800001);
        pulse_refresh();
        repeat (100) tick();
        pulse_refresh();
        write_pix(2'd1, 24'h00FF00);
        write_pix(2'd0, 24'h0000FF);
        pulse_refresh();
        push_frame(24'h0000FF, 24'h00FF00, 24'h800001);
        run_until_done(2, 2 * FRAME_BUDGET, fb, lb, gap);
        check("f2_busy_at_done", fb, 1);
        check("f3_busy_at_done", lb, 0);
        check("f23_busy_gap", gap, 0);
        repeat (100) tick();
        check("f23_no_third_frame", mon_frames, 3);
        check("f23_idle_busy", bus.busy, 0);

        // F4: reset in the middle of the first HIGH phase
        pulse_refresh();
        repeat (5) tick();
        check("f4_ws_high_before_rst", bus.ws_out, 1);
        rst = 1'b1;
        tick();
        check("f4_ws_after_rst", bus.ws_out, 0);
        check("f4_busy_after_rst", bus.busy, 0);
        rst = 1'b0;
        repeat (200) tick();
        check("f4_no_frame_done", mon_frames, 3);
        check("f4_state_idle", bus.dbg_state, IDLE);

        // refresh together with reset: nothing starts
        rst = 1'b1;
        bus.refresh_req = 1'b1;
        tick();
        rst = 1'b0;
        bus.refresh_req = 1'b0;
        repeat (4) tick();
        check("rst_refresh_busy", bus.busy, 0);
        check("rst_refresh_state", bus.dbg_state, IDLE);
        check("rst_refresh_ws", bus.ws_out, 0);

        // F5: restart from pixel 0; write to pixel 0 in its LOAD cycle
        push_frame(24'h0000FF, 24'h00FF00, 24'h800001);
        pulse_refresh();
        write_pix(2'd0, 24'h5A5A5A);
        run_until_done(1, FRAME_BUDGET, fb, lb, gap);
        check("f5_busy_at_done", lb, 0);

        // F6: out-of-range write leaves the buffer alone
        write_pix(2'd3, 24'h123456);
        push_frame(24'h5A5A5A, 24'h00FF00, 24'h800001);
        refresh_from_idle_checked();
        run_until_done(1, FRAME_BUDGET, fb, lb, gap);
        repeat (20) tick();
        check("total_frames", mon_frames, 5);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
